// File: rtl/dso_fir_pkg.sv
// Shared constants, types and helpers for the DSO FIR filter.
package dso_fir_pkg;

  localparam int DW_DEF   = 8;
  localparam int TAPS_DEF = 16;
  localparam int CW_DEF   = 12;
  localparam int CF_DEF   = 10;
  localparam int GW_DEF   = 10;

  localparam int GAIN_FRAC  = 8;
  localparam int GAIN_UNITY = 256;
  localparam int PIPE_LAT   = 5;

  // Tap-0 value of the identity response at the default coefficient format.
  localparam int ID_COEF_TAP0 = 1 << CF_DEF;

  typedef struct packed {
    logic valid;
    logic fir;
    logic clip;
  } stage_ctl_t;

  function automatic int id_coef(input int tap, input int cf);
    return (tap == 0) ? (1 << cf) : 0;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift by SH, then saturate to signed OW bits.
module fir_round_sat #(
  parameter int IW = 24,
  parameter int OW = 8,
  parameter int SH = 10
) (
  input  logic signed [IW-1:0] din_i,
  output logic signed [OW-1:0] dout_o,
  output logic                 ovf_o
);

  localparam logic signed [IW:0] RND   = (IW+1)'(2**(SH-1));
  localparam logic signed [IW:0] MAX_V = (IW+1)'(2**(OW-1) - 1);
  localparam logic signed [IW:0] MIN_V = -((IW+1)'(2**(OW-1)));

  logic signed [IW:0] sum;
  logic signed [IW:0] shr;

  // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
  always_comb begin
    sum    = $signed({din_i[IW-1], din_i}) + RND;
    shr    = sum >>> SH;
    dout_o = shr[OW-1:0];
    ovf_o  = 1'b0;
    if (shr > MAX_V) begin
      dout_o = MAX_V[OW-1:0];
      ovf_o  = 1'b1;
    end else if (shr < MIN_V) begin
      dout_o = MIN_V[OW-1:0];
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/dso_fir_filter.sv
// Five-stage pipelined FIR with double-buffered coefficients, gain compensation,
// delay-matched bypass and a sticky clip indicator.
module dso_fir_filter
  import dso_fir_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int CW   = CW_DEF,
  parameter int CF   = CF_DEF,
  parameter int GW   = GW_DEF
) (
  input  logic                    ad_clk,
  input  logic                    rst_n,
  input  logic [DW-1:0]           ad_data,
  input  logic                    ad_valid,
  input  logic                    fir_en,
  input  logic [GW-1:0]           gain,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_wdata,
  input  logic                    coef_commit,
  input  logic                    clip_clr,
  output logic [DW-1:0]           ad_data_out,
  output logic                    ad_valid_out,
  output logic                    clip_flag
);

  localparam int PW  = DW + CW;
  localparam int AW  = DW + CW + $clog2(TAPS);
  localparam int GPW = DW + GW + 1;

  typedef logic signed [DW-1:0] samp_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [AW-1:0] acc_t;

  coef_t shadow_q [TAPS];
  coef_t active_q [TAPS];
  samp_t hist_q   [TAPS-1];
  samp_t win      [TAPS];
  prod_t prod_d   [TAPS];
  prod_t prod_q   [TAPS];

  stage_ctl_t s1_ctl_q, s2_ctl_q, s3_ctl_q, s4_ctl_q;
  samp_t      s1_byp_q, s2_byp_q, s3_byp_q, s4_byp_q;
  acc_t       acc_d, acc_q;
  samp_t      s3_q, s4_q;
  samp_t      rs3_y, rs4_y;
  logic       rs3_ovf, rs4_ovf;
  logic signed [GPW-1:0] gprod;

  logic [DW-1:0] out_q;
  logic          valid_out_q;
  logic          clip_flag_q;
  logic          clip_set;

  samp_t x_in;
  // Flipping the MSB of offset-binary is the same as subtracting 2^(DW-1).
  assign x_in = {~ad_data[DW-1], ad_data[DW-2:0]};

  // NOTE: both coefficient banks are reset explicitly because the identity response must be live straight out of reset.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_q[i] <= coef_t'(id_coef(i, CF));
        active_q[i] <= coef_t'(id_coef(i, CF));
      end
    end else begin
      if (coef_commit) begin
        for (int i = 0; i < TAPS; i++) active_q[i] <= shadow_q[i];
      end
      if (coef_we) shadow_q[coef_addr] <= coef_wdata;
    end
  end

  always_comb begin
    win[0] = x_in;
    for (int i = 1; i < TAPS; i++) win[i] = hist_q[i-1];
    for (int i = 0; i < TAPS; i++) prod_d[i] = prod_t'(win[i]) * prod_t'(active_q[i]);
  end

  // S1: delay line and per-tap products, both advancing only on a valid sample.
  // NOTE: sequential state uses non-blocking '<=' so each stage captures the previous stage's pre-edge value.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS-1; i++) hist_q[i] <= '0;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
      s1_ctl_q <= '0;
      s1_byp_q <= '0;
    end else begin
      s1_ctl_q <= '{valid: ad_valid, fir: fir_en, clip: 1'b0};
      if (ad_valid) begin
        hist_q[0] <= x_in;
        for (int i = 1; i < TAPS-1; i++) hist_q[i] <= hist_q[i-1];
        for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
        s1_byp_q <= x_in;
      end
    end
  end

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < TAPS; i++) acc_d = acc_d + AW'(prod_q[i]);
  end

  fir_round_sat #(.IW(AW), .OW(DW), .SH(CF)) u_rs_s3 (
    .din_i  (acc_q),
    .dout_o (rs3_y),
    .ovf_o  (rs3_ovf)
  );

  assign gprod = GPW'(s3_q) * GPW'($signed({1'b0, gain}));

  fir_round_sat #(.IW(GPW), .OW(DW), .SH(GAIN_FRAC)) u_rs_s4 (
    .din_i  (gprod),
    .dout_o (rs4_y),
    .ovf_o  (rs4_ovf)
  );

  // A clip only counts for a filtered sample actually leaving S5.
  assign clip_set = s4_ctl_q.valid & s4_ctl_q.clip;

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_ctl_q    <= '0;
      s3_ctl_q    <= '0;
      s4_ctl_q    <= '0;
      s2_byp_q    <= '0;
      s3_byp_q    <= '0;
      s4_byp_q    <= '0;
      acc_q       <= '0;
      s3_q        <= '0;
      s4_q        <= '0;
      out_q       <= '0;
      valid_out_q <= 1'b0;
      clip_flag_q <= 1'b0;
    end else begin
      s2_ctl_q <= s1_ctl_q;
      if (s1_ctl_q.valid) begin
        acc_q    <= acc_d;
        s2_byp_q <= s1_byp_q;
      end

      s3_ctl_q <= '{valid: s2_ctl_q.valid, fir: s2_ctl_q.fir, clip: s2_ctl_q.fir & rs3_ovf};
      if (s2_ctl_q.valid) begin
        s3_q     <= rs3_y;
        s3_byp_q <= s2_byp_q;
      end

      s4_ctl_q <= '{valid: s3_ctl_q.valid, fir: s3_ctl_q.fir,
                    clip: s3_ctl_q.clip | (s3_ctl_q.fir & rs4_ovf)};
      if (s3_ctl_q.valid) begin
        s4_q     <= rs4_y;
        s4_byp_q <= s3_byp_q;
      end

      valid_out_q <= s4_ctl_q.valid;
      if (s4_ctl_q.valid) begin
        if (s4_ctl_q.fir) out_q <= {~s4_q[DW-1], s4_q[DW-2:0]};
        else              out_q <= {~s4_byp_q[DW-1], s4_byp_q[DW-2:0]};
      end

      // Set wins over a simultaneous clear.
      clip_flag_q <= clip_set | (clip_flag_q & ~clip_clr);
    end
  end

  assign ad_data_out  = out_q;
  assign ad_valid_out = valid_out_q;
  assign clip_flag    = clip_flag_q;

endmodule

// File: tb/tb_dso_fir_filter.sv
// Directed bench for dso_fir_filter with hand-computed expected outputs.
module tb_dso_fir_filter;
  import dso_fir_pkg::*;

  localparam int DW    = 8;
  localparam int TAPS  = 16;
  localparam int CW    = 12;
  localparam int CF    = 10;
  localparam int GW    = 10;
  localparam int ABITS = $clog2(TAPS);

  logic             ad_clk = 1'b0;
  logic             rst_n;
  logic [DW-1:0]    ad_data;
  logic             ad_valid;
  logic             fir_en;
  logic [GW-1:0]    gain;
  logic             coef_we;
  logic [ABITS-1:0] coef_addr;
  logic [CW-1:0]    coef_wdata;
  logic             coef_commit;
  logic             clip_clr;
  logic [DW-1:0]    ad_data_out;
  logic             ad_valid_out;
  logic             clip_flag;

  int vectors     = 0;
  int miscompares = 0;

  always #5 ad_clk = ~ad_clk;

  dso_fir_filter #(.DW(DW), .TAPS(TAPS), .CW(CW), .CF(CF), .GW(GW)) dut (
    .ad_clk       (ad_clk),
    .rst_n        (rst_n),
    .ad_data      (ad_data),
    .ad_valid     (ad_valid),
    .fir_en       (fir_en),
    .gain         (gain),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .coef_commit  (coef_commit),
    .clip_clr     (clip_clr),
    .ad_data_out  (ad_data_out),
    .ad_valid_out (ad_valid_out),
    .clip_flag    (clip_flag)
  );

  task automatic tick();
    @(posedge ad_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int d);
    ad_data  = DW'(d);
    ad_valid = 1'b1;
    tick();
    ad_valid = 1'b0;
  endtask

  task automatic stream(input int d, input int n);
    ad_data  = DW'(d);
    ad_valid = 1'b1;
    repeat (n) tick();
    ad_valid = 1'b0;
  endtask

  task automatic drain();
    ad_valid = 1'b0;
    repeat (PIPE_LAT + 1) tick();
  endtask

  task automatic pulse_clr();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
  endtask

  task automatic pulse_commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  initial begin
    int d7 [4];
    int e7 [4];
    int seen;
    logic [7:0] pat;

    rst_n = 1'b0; ad_data = '0; ad_valid = 1'b0; fir_en = 1'b1;
    gain = GW'(GAIN_UNITY); coef_we = 1'b0; coef_addr = '0;
    coef_wdata = '0; coef_commit = 1'b0; clip_clr = 1'b0;

    tick(); tick();
    check("rst_data", ad_data_out, 0);
    check("rst_valid", ad_valid_out, 0);
    check("rst_clip", clip_flag, 0);
    rst_n = 1'b1;
    tick();

    // Identity, unity gain, one sample: valid exactly PIPE_LAT cycles later.
    send(200);
    repeat (PIPE_LAT - 2) tick();
    check("lat_early_valid", ad_valid_out, 0);
    tick();
    check("lat_valid", ad_valid_out, 1);
    check("lat_data", ad_data_out, 200);
    check("lat_clip", clip_flag, 0);
    tick();
    check("lat_single_pulse", ad_valid_out, 0);

    // Gain 484 on DC 160: 32*484=15488 -> 61 -> 189.
    gain = GW'(484);
    stream(160, 8);
    check("gain484_data", ad_data_out, 189);
    check("gain484_valid", ad_valid_out, 1);
    check("gain484_clip", clip_flag, 0);
    drain();

    gain = '0;
    stream(230, 8);
    check("gain0_mid", ad_data_out, 128);
    drain();

    // Gain 2.0 on full scale: saturates, flag rises with that output.
    gain = GW'(512);
    ad_data = DW'(255);
    ad_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) check("clip_before_out", clip_flag, 0);
    end
    ad_valid = 1'b0;
    check("sat_pos_data", ad_data_out, 255);
    check("sat_pos_clip", clip_flag, 1);
    drain();
    pulse_clr();
    check("clip_cleared", clip_flag, 0);

    send(255);
    repeat (3) tick();
    check("clip_pre_collide", clip_flag, 0);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip_set_wins", clip_flag, 1);
    pulse_clr();

    send(0);
    repeat (4) tick();
    check("sat_neg_data", ad_data_out, 0);
    check("sat_neg_clip", clip_flag, 1);
    pulse_clr();

    fir_en = 1'b0;
    send(255);
    repeat (4) tick();
    check("byp_data", ad_data_out, 255);
    check("byp_valid", ad_valid_out, 1);
    check("byp_no_clip", clip_flag, 0);
    fir_en = 1'b1;
    gain = GW'(GAIN_UNITY);
    drain();

    // Moving average: 16 taps of 64/1024, step 128 -> 192.
    coef_we = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      coef_addr  = ABITS'(i);
      coef_wdata = CW'(64);
      tick();
    end
    coef_we = 1'b0;
    send(200);
    repeat (4) tick();
    check("shadow_isolated", ad_data_out, 200);
    pulse_commit();
    ad_valid = 1'b1;
    for (int i = 0; i < 36; i++) begin
      ad_data = (i < 16) ? DW'(128) : DW'(192);
      tick();
      if (i >= 20) check($sformatf("avg_step_k%0d", i - 19), ad_data_out, 128 + 4 * (i - 19));
    end
    ad_valid = 1'b0;
    drain();

    // Reload identity while streaming; commit and a shadow write share a valid cycle.
    d7 = '{128, 200, 100, 50};
    e7 = '{188, 200, 100, 50};
    for (int i = 0; i < 29; i++) begin
      ad_valid    = (i < 24);
      ad_data     = (i < 20) ? DW'(192) : (i < 24) ? DW'(d7[i-20]) : DW'(0);
      fir_en      = (i != 22);
      coef_we     = (i < 16) || (i == 20);
      coef_addr   = (i < 16) ? ABITS'(i) : '0;
      coef_wdata  = (i == 0) ? CW'(ID_COEF_TAP0) : '0;
      coef_commit = (i == 20);
      tick();
      if (i == 19) check("old_coef_streaming", ad_data_out, 192);
      if (i >= 24 && i < 28) begin
        check($sformatf("commit_seq_data%0d", i - 24), ad_data_out, e7[i-24]);
        check($sformatf("commit_seq_valid%0d", i - 24), ad_valid_out, 1);
      end
      if (i == 28) check("commit_seq_end", ad_valid_out, 0);
    end
    coef_we = 1'b0; coef_commit = 1'b0; fir_en = 1'b1; ad_valid = 1'b0;
    drain();

    // Shadow now all-zero: commit it, stream with gaps, then reset mid-flight.
    pulse_commit();
    pat = 8'b0110_1101;
    for (int i = 0; i < 8; i++) begin
      ad_valid = pat[i];
      ad_data  = DW'(200);
      tick();
      if (i == 4) check("zero_bank_data", ad_data_out, 128);
    end
    ad_valid = 1'b0;
    check("pre_rst_inflight", ad_valid_out, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", ad_data_out, 0);
    check("mid_rst_valid", ad_valid_out, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen += int'(ad_valid_out);
    end
    check("rst_no_spurious", seen, 0);

    send(200);
    repeat (3) tick();
    check("post_rst_early", ad_valid_out, 0);
    tick();
    check("post_rst_valid", ad_valid_out, 1);
    check("post_rst_identity", ad_data_out, 200);
    pulse_commit();
    send(90);
    repeat (4) tick();
    check("post_rst_shadow_id", ad_data_out, 90);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
